// File: rtl/sprite_mem_arbiter.sv
// Sprite image memory arbiter: video scanout reads take strict priority over a
// host read/write port; read data returns to its requester via a tag pipe.
module sprite_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_rvalid,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  clear_stats,
  output logic [STAT_WIDTH-1:0] host_wait_max
);

  typedef enum logic [1:0] {StIdle, StPend, StRdWait} host_st_e;

  host_st_e              host_st;
  logic [READ_LATENCY:0] tag_valid;
  logic [READ_LATENCY:0] tag_host;
  logic [STAT_WIDTH-1:0] host_wait;

  logic                  host_grant;
  logic                  tail_vid;
  logic                  tail_host;
  logic [STAT_WIDTH-1:0] wait_inc;
  logic [STAT_WIDTH-1:0] wait_peak;

  always_comb begin
    host_grant = (host_st == StPend) && host_req && !vid_req;
    tail_vid   = tag_valid[READ_LATENCY] && !tag_host[READ_LATENCY];
    tail_host  = tag_valid[READ_LATENCY] && tag_host[READ_LATENCY];
    wait_inc   = (&host_wait) ? host_wait : host_wait + STAT_WIDTH'(1);
    wait_peak  = (host_wait > host_wait_max) ? host_wait : host_wait_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_st       <= StIdle;
      host_wait     <= '0;
      host_wait_max <= '0;
      tag_valid     <= '0;
      tag_host      <= '0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_we        <= 1'b0;
      host_ack      <= 1'b0;
      vid_rvalid    <= 1'b0;
      vid_rdata     <= '0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
    end else begin
      mem_we   <= 1'b0;
      host_ack <= host_grant;
      if (vid_req) begin
        mem_addr <= vid_addr;
      end else if (host_grant) begin
        mem_addr <= host_addr;
        mem_din  <= host_wdata;
        mem_we   <= host_we;
      end

      // Writes enter the pipe as empty slots so the tail stays latency-aligned.
      tag_valid <= {tag_valid[READ_LATENCY-1:0], vid_req | (host_grant & ~host_we)};
      tag_host  <= {tag_host[READ_LATENCY-1:0], host_grant};

      vid_rvalid  <= tail_vid;
      host_rvalid <= tail_host;
      if (tail_vid)  vid_rdata  <= mem_dout;
      if (tail_host) host_rdata <= mem_dout;

      // A clear coinciding with a grant leaves exactly that grant's wait.
      if (host_grant) begin
        host_wait_max <= clear_stats ? host_wait : wait_peak;
      end else if (clear_stats) begin
        host_wait_max <= '0;
      end

      case (host_st)
        StIdle: begin
          if (host_req) begin
            host_st   <= StPend;
            host_wait <= '0;
          end
        end
        StPend: begin
          if (!host_req) begin
            host_st <= StIdle;
          end else if (vid_req) begin
            host_wait <= wait_inc;
          end else begin
            host_st <= host_we ? StIdle : StRdWait;
          end
        end
        StRdWait: begin
          if (tail_host) host_st <= StIdle;
        end
        default: host_st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Randomized bench for sprite_mem_arbiter: a cycle-indexed transaction model
// schedules expected returns, tracks a write log and the host wait statistics.
module tb_sprite_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam int RL = 2;
  localparam int SW = 16;
  localparam int SatMax = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vid_req, host_req, host_we, clear_stats;
  logic [AW-1:0] vid_addr, host_addr, mem_addr;
  logic [DW-1:0] host_wdata, vid_rdata, host_rdata, mem_din, mem_dout;
  logic          vid_rvalid, host_ack, host_rvalid, mem_we;
  logic [SW-1:0] host_wait_max;

  sprite_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .STAT_WIDTH  (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_rvalid   (vid_rvalid),
    .vid_rdata    (vid_rdata),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout),
    .clear_stats  (clear_stats),
    .host_wait_max(host_wait_max)
  );

  // Image memory: samples mem_addr each edge, dout valid RL-1 edges later.
  logic [DW-1:0] ram   [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:3];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    forever begin
      @(posedge clk);
      rpipe[0] <= ram[mem_addr];
      for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
      if (mem_we) ram[mem_addr] = mem_din;
    end
  end
  assign mem_dout = rpipe[RL-1];

  // Reference model state
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            phase = 0;      // 0 none, 1 awaiting grant, 2 read in flight
  int            done_edge = 0;
  int            m_wait = 0;
  int            m_max = 0;
  logic [DW-1:0] ref_wr [int];
  bit            ev_v [8];
  bit            ev_h [8];
  logic [DW-1:0] ev_vd [8];
  logic [DW-1:0] ev_hd [8];
  logic [DW-1:0] x_vd = '0, x_hd = '0, x_din = '0;
  logic [AW-1:0] x_addr = '0;
  bit            x_ack = 1'b0, x_we = 1'b0, granted_h = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : DW'(a);
  endfunction

  // Apply the inputs present now to the model for the coming edge.
  task automatic model_edge();
    int e = cyc + 1;
    int s;
    granted_h = 1'b0;
    x_ack = 1'b0;
    x_we = 1'b0;
    if (rst) begin
      phase = 0; m_wait = 0; m_max = 0;
      x_addr = '0; x_din = '0; x_vd = '0; x_hd = '0;
      for (int k = 0; k < 8; k++) begin ev_v[k] = 1'b0; ev_h[k] = 1'b0; end
      return;
    end
    if (vid_req) begin
      x_addr = vid_addr;
      s = (e + RL + 1) % 8;
      ev_v[s] = 1'b1;
      ev_vd[s] = ref_rd(vid_addr);
    end else if (phase == 1 && host_req) begin
      granted_h = 1'b1;
      x_ack = 1'b1;
      x_addr = host_addr;
      x_din = host_wdata;
      x_we = host_we;
      m_max = clear_stats ? m_wait : (m_wait > m_max ? m_wait : m_max);
      if (host_we) begin
        ref_wr[int'(host_addr)] = host_wdata;
        phase = 0;
      end else begin
        s = (e + RL + 1) % 8;
        ev_h[s] = 1'b1;
        ev_hd[s] = ref_rd(host_addr);
        phase = 2;
        done_edge = e + RL + 1;
      end
    end
    if (!granted_h && clear_stats) m_max = 0;
    if (!granted_h) begin
      case (phase)
        0: if (host_req) begin phase = 1; m_wait = 0; end
        1: begin
          if (!host_req) phase = 0;
          else if (vid_req && m_wait < SatMax) m_wait++;
        end
        2: if (e == done_edge) phase = 0;
        default: phase = 0;
      endcase
    end
  endtask

  task automatic step();
    int s;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % 8;
    if (ev_v[s]) x_vd = ev_vd[s];
    if (ev_h[s]) x_hd = ev_hd[s];
    check("vid_rvalid", vid_rvalid, ev_v[s]);
    check("vid_rdata", vid_rdata, x_vd);
    check("host_rvalid", host_rvalid, ev_h[s]);
    check("host_rdata", host_rdata, x_hd);
    check("host_ack", host_ack, x_ack);
    check("mem_we", mem_we, x_we);
    check("mem_addr", mem_addr, x_addr);
    if (x_we) check("mem_din", mem_din, x_din);
    check("host_wait_max", host_wait_max, m_max);
    ev_v[s] = 1'b0;
    ev_h[s] = 1'b0;
    if (granted_h) host_req = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic host_go(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic wait_host(input int budget);
    for (int n = 0; n < budget && host_req; n++) step();
  endtask

  initial begin
    rst = 1'b1; vid_req = 1'b0; vid_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; clear_stats = 1'b0;
    run(2);
    rst = 1'b0;
    run(2);

    // Video burst 0..3
    for (int i = 0; i < 4; i++) begin vid_req = 1'b1; vid_addr = AW'(i); step(); end
    vid_req = 1'b0;
    run(6);

    // Host write then read back
    host_go(1'b1, 14'h0040, 12'hABC);
    wait_host(10);
    run(2);
    host_go(1'b0, 14'h0040, 12'h000);
    wait_host(10);
    run(5);
    check("host_rd_abc", host_rdata, 12'hABC);

    // Host read stalled behind video
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    vid_req = 1'b1; vid_addr = 14'h0020;
    host_go(1'b0, 14'h0010, 12'h000);
    run(11);
    vid_req = 1'b0;
    wait_host(5);
    run(1);
    check("wait_max_10", host_wait_max, 10);
    run(4);

    // Interleave with a one-cycle gap in video
    host_go(1'b0, 14'h0007, 12'h000);
    vid_req = 1'b1; vid_addr = 14'h0001; step();
    vid_addr = 14'h0002; step();
    vid_req = 1'b0; step();
    vid_req = 1'b1; vid_addr = 14'h0003; step();
    vid_addr = 14'h0004; step();
    vid_req = 1'b0;
    run(6);

    // Reset with reads in flight
    host_go(1'b0, 14'h0009, 12'h000);
    run(2);
    vid_req = 1'b1; vid_addr = 14'h000A; step();
    vid_addr = 14'h000B; step();
    vid_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    run(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      vid_req = ($urandom_range(0, 9) < 5);
      vid_addr = AW'($urandom_range(0, 63));
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_go(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom));
      end else if (host_req && $urandom_range(0, 40) == 0) begin
        host_req = 1'b0;
      end
      clear_stats = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    vid_req = 1'b0; host_req = 1'b0; clear_stats = 1'b0; rst = 1'b0;
    run(8);

    // Wait counter saturation
    rst = 1'b1; step(); rst = 1'b0;
    vid_req = 1'b1; vid_addr = 14'h0005;
    host_go(1'b0, 14'h0011, 12'h000);
    run(70000);
    vid_req = 1'b0;
    wait_host(5);
    run(1);
    check("wait_sat", host_wait_max, 32'h0000FFFF);
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    check("wait_clear", host_wait_max, 0);
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_mem_arbiter.md
# sprite_mem_arbiter

Shares the single user-side port of the sprite image memory between two requesters: the VGA scanout reader (hard real-time, strict priority) and a host port used by a sprite-update engine for reads and writes. Sits between the pixel pipeline and the image memory's user port, in the 65 MHz pixel clock domain. It registers the memory control signals and tags each issued read with its requester. It routes read data back to that requester after the fixed memory latency, and records how long host requests stall behind video.

## Interface
- ADDR_WIDTH, 14: image memory address width (128×128 sprite).
- DATA_WIDTH, 12: pixel width (4:4:4 RGB).
- READ_LATENCY, 2: memory cycles from address sampled to dout valid; legal 1–4.
- STAT_WIDTH, 16: width of the wait statistics counters.

- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vid_req  in  1  video read request, one read per asserted cycle.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DATA_WIDTH  video read data.
- host_req  in  1  host request; hold with addr/we/wdata stable until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle pulse: host request issued to memory.
- host_rvalid  out  1  one-cycle pulse: host read data valid.
- host_rdata  out  DATA_WIDTH  host read data.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_din  out  DATA_WIDTH  registered memory write data.
- mem_we  out  1  registered memory write enable.
- mem_dout  in  DATA_WIDTH  memory read data.
- clear_stats  in  1  clears host_wait_max.
- host_wait_max  out  STAT_WIDTH  largest host wait observed (cycles), saturating.

## Operation
- Arbitration per cycle: vid_req wins unconditionally. Host is granted only when vid_req=0 and host FSM is PEND.
- Host FSM:
  - IDLE → PEND on host_req.
  - PEND → IDLE on grant of a write.
  - PEND → RDWAIT on grant of a read.
  - PEND → IDLE if host_req drops before grant (withdrawal, no ack).
  - RDWAIT → IDLE in the cycle host_rvalid pulses.
  - host_req is ignored in RDWAIT: one outstanding host read max.
- Issue: at the grant edge, mem_addr/mem_din/mem_we load from the winner. Video always loads mem_we=0. When nothing is granted, mem_we=0 and mem_addr holds its value.
- Return routing: a tag shift register of depth READ_LATENCY+1 carries {valid, is_host} per issued read; writes insert an empty tag. At the tail, mem_dout drives vid_rdata or host_rdata and pulses the matching rvalid. rdata registers hold their last value otherwise.
- Stats: host_wait counter counts cycles in PEND with vid_req=1. It resets to 0 on entering PEND. On grant, host_wait_max ← max(host_wait_max, host_wait). Both saturate at all-ones.
- clear_stats zeroes host_wait_max. If a grant occurs in the same cycle, the post-clear value equals that grant's wait.

## Timing
- Reset values: every output 0, FSM IDLE, tag pipe empty, wait counters 0.
- Video read sampled at edge N → mem_addr valid after N → vid_rvalid/vid_rdata valid in the cycle after edge N+READ_LATENCY+1.
- With the default READ_LATENCY=2, vid_rvalid pulses 3 cycles after vid_req.
- Back-to-back video reads every cycle give back-to-back vid_rvalid with no bubbles.
- Host grant at edge N: host_ack high in cycle N+1, concurrent with mem signals. For reads, host_rvalid comes at the same offset as video (READ_LATENCY+1).
- A host write with vid_req=0 and FSM already PEND is acked 1 cycle after grant. Minimum host_req-to-ack is 2 cycles, because IDLE→PEND takes one edge.
- Simultaneous vid_req and host grant is impossible; video always displaces host.
- rst mid-operation discards all in-flight tags, so no rvalid pulses after reset. mem_we drops the cycle after the rst edge.

## Test plan
- Video only, vid_req high for 4 cycles at addrs 0x0000–0x0003, memory model dout = addr[11:0]: vid_rvalid for 4 consecutive cycles, starting 3 cycles after first request, rdata 0x000–0x003.
- Host write addr 0x0040, data 0xABC, vid_req=0: host_ack pulses once. mem_we=1 for exactly one cycle with mem_addr=0x0040 and mem_din=0xABC. A subsequent host read of 0x0040 returns 0xABC on host_rvalid.
- Host read pending while vid_req held for 10 cycles: no host_ack during those cycles. Ack in the cycle after vid_req drops + 1, and host_wait_max=10.
- Interleave video reads and a host read with a 1-cycle gap in vid_req: each rvalid goes only to its requester with the correct data, and there is never a double pulse.
- Assert rst with 2 video reads and 1 host read in flight: no vid_rvalid or host_rvalid afterwards, and all outputs are 0 the cycle after reset.
- host_wait saturation: keep vid_req high for 70000 cycles with host pending → host_wait_max=0xFFFF. Pulse clear_stats → 0.
